// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the fetch stage's instruction-memory port, its decode-side handshake
// and the redirect inputs coming back from the controller.
//   master : the fetch unit (drives the imem request and the instruction side)
//   slave  : the environment (instruction memory plus downstream controller)
// Signals:
//   imem_req_o/imem_addr_o       fetch request pulse and word address
//   imem_rvalid_i/imem_rdata_i   memory response
//   instr_valid_o/instr_ready_i  instruction handshake toward decode
//   instr_o/pc_o                 fetched word and its PC
//   op_code_o/funct3_o/fnc7_h20_o  decoded field slices of instr_o
//   redirect_i/redirect_pc_i     taken control-flow target for the held instr
//   fetch_err_o                  sticky misaligned-target error
// -----------------------------------------------------------------------------
interface fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [6:0]  op_code_o;
  logic [2:0]  funct3_o;
  logic        fnc7_h20_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        fetch_err_o;

  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
           op_code_o, funct3_o, fnc7_h20_o, fetch_err_o,
    input  imem_rvalid_i, imem_rdata_i, instr_ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
           op_code_o, funct3_o, fnc7_h20_o, fetch_err_o,
    output imem_rvalid_i, imem_rdata_i, instr_ready_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage feeding the decode controller. Holds the PC, issues
// one request per instruction on the imem port, waits for the response, then
// holds the instruction (with decoded op_code/funct3/funct7[5]) until decode
// accepts it. On acceptance the next PC is either PC+4 (wrapping) or the
// redirect target; a misaligned next PC parks the unit in a sticky error state.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset, highest priority in every state
//   bus    : fetch_unit_if.master (imem port, decode handshake, redirect, error)
// Parameter:
//   RESET_PC : word-aligned PC loaded on reset
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_unit_if.master bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [2:0]  state_r;
  logic [2:0]  state_s;
  logic [31:0] pc_r;
  logic [31:0] pc_s;
  logic [31:0] instr_r;
  logic [31:0] instr_s;
  logic [31:0] next_pc_s;
  logic        req_r;
  logic        valid_r;
  logic        err_r;

  // Next-state, next-PC selection and response capture.
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    instr_s   = instr_r;
    // Redirect only matters on the HOLD+ready path below; elsewhere unused.
    next_pc_s = bus.redirect_i ? bus.redirect_pc_i : (pc_r + 32'd4);
    case (state_r)
      ST_IDLE: begin
        state_s = ST_REQ;
      end
      ST_REQ: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.imem_rvalid_i) begin
          instr_s = bus.imem_rdata_i;
          state_s = ST_HOLD;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (bus.instr_ready_i) begin
          // A misaligned target is never loaded: PC keeps the faulting instr.
          if (next_pc_s[1:0] != 2'b00) begin
            state_s = ST_ERR;
          end else begin
            pc_s    = next_pc_s;
            state_s = ST_REQ;
          end
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_ERR: begin
        state_s = ST_ERR;
      end
      default: begin
        // Corrupted encoding: stop fetching and flag it rather than guess.
        state_s = ST_ERR;
      end
    endcase
  end

  // State, PC, instruction and the registered per-state output flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      pc_r    <= RESET_PC;
      instr_r <= NOP_INSTR;
      req_r   <= 1'b0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      instr_r <= instr_s;
      // Flags are decoded from the next state so they are plain flops.
      req_r   <= (state_s == ST_REQ);
      valid_r <= (state_s == ST_HOLD);
      err_r   <= (state_s == ST_ERR);
    end
  end

  assign bus.imem_req_o    = req_r;
  assign bus.imem_addr_o   = pc_r;
  assign bus.instr_valid_o = valid_r;
  assign bus.instr_o       = instr_r;
  assign bus.pc_o          = pc_r;
  assign bus.op_code_o     = instr_r[6:0];
  assign bus.funct3_o      = instr_r[14:12];
  assign bus.fnc7_h20_o    = instr_r[30];
  assign bus.fetch_err_o   = err_r;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Randomized bench for fetch_unit. A cycle-level transaction model tracks the
// expected PC, the cycle of the next request, the cycle the instruction becomes
// valid and the sticky error; an in-bench memory answers each request after a
// configurable latency. Inputs are driven and outputs sampled 1 time unit
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk;
  logic rst;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  int cyc;
  int lat;
  int p_ready;
  int p_redir;
  int exp_req_cyc;
  int exp_valid_cyc;
  int mem_due;
  logic [31:0] pc_exp;
  logic [31:0] cur_word;
  bit          err_exp;
  logic [32:0] force_q[$];
  logic [31:0] word_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic reset_model();
    pc_exp        = RST_PC;
    exp_req_cyc   = -1;
    exp_valid_cyc = -1;
    mem_due       = -1;
    err_exp       = 1'b0;
    force_q.delete();
    word_q.delete();
  endtask

  // One clock: sample and check outputs, advance the model, drive inputs.
  task automatic cycle();
    bit          rst_seen;
    bit          req_exp;
    bit          valid_now;
    logic [32:0] f;
    logic [31:0] nxt;
    @(posedge clk);
    #1;
    cyc++;
    rst_seen  = rst;
    valid_now = 1'b0;
    if (rst_seen) begin
      check_val("rst_req",   {31'd0, bus.imem_req_o},    32'd0);
      check_val("rst_valid", {31'd0, bus.instr_valid_o}, 32'd0);
      check_val("rst_err",   {31'd0, bus.fetch_err_o},   32'd0);
      check_val("rst_pc",    bus.pc_o,                   RST_PC);
      check_val("rst_addr",  bus.imem_addr_o,            RST_PC);
      check_val("rst_instr", bus.instr_o,                32'h0000_0013);
      check_val("rst_op",    {25'd0, bus.op_code_o},     32'h13);
      check_val("rst_f3",    {29'd0, bus.funct3_o},      32'd0);
      check_val("rst_f7",    {31'd0, bus.fnc7_h20_o},    32'd0);
    end else begin
      req_exp   = (cyc == exp_req_cyc);
      valid_now = (exp_valid_cyc >= 0) && (cyc >= exp_valid_cyc);
      check_val("err",   {31'd0, bus.fetch_err_o},   {31'd0, err_exp});
      check_val("req",   {31'd0, bus.imem_req_o},    {31'd0, req_exp});
      check_val("valid", {31'd0, bus.instr_valid_o}, {31'd0, valid_now});
      check_val("addr",  bus.imem_addr_o, pc_exp);
      check_val("pc",    bus.pc_o,        pc_exp);
      if (valid_now) begin
        check_val("instr", bus.instr_o,               cur_word);
        check_val("op",    {25'd0, bus.op_code_o},    cur_word & 32'h7F);
        check_val("f3",    {29'd0, bus.funct3_o},     (cur_word >> 12) & 32'd7);
        check_val("f7h",   {31'd0, bus.fnc7_h20_o},   (cur_word >> 30) & 32'd1);
      end
      if (req_exp) begin
        mem_due       = cyc + lat;
        exp_valid_cyc = cyc + lat + 1;
        exp_req_cyc   = -1;
        if (word_q.size() > 0) cur_word = word_q.pop_front();
        else                   cur_word = $urandom();
      end
    end

    // Memory: one response per request, plus stray pulses that must be ignored.
    if (!rst && cyc == mem_due) begin
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = cur_word;
    end else if ((valid_now || err_exp) && $urandom_range(0, 3) == 0) begin
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = $urandom();
    end else begin
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = $urandom();
    end

    bus.instr_ready_i = ($urandom_range(1, 100) <= p_ready);
    bus.redirect_i    = ($urandom_range(1, 100) <= p_redir);
    if (bus.redirect_i) bus.redirect_pc_i = $urandom() & 32'hFFFF_FFFC;
    else                bus.redirect_pc_i = $urandom();

    if (!rst && valid_now && bus.instr_ready_i) begin
      if (force_q.size() > 0) begin
        f = force_q.pop_front();
        bus.redirect_i    = f[32];
        bus.redirect_pc_i = f[31:0];
      end
      nxt = bus.redirect_i ? bus.redirect_pc_i : pc_exp + 32'd4;
      exp_valid_cyc = -1;
      if (nxt % 4 != 0) begin
        err_exp = 1'b1;
      end else begin
        pc_exp      = nxt;
        exp_req_cyc = cyc + 1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    reset_model();
    cycle();
    cycle();
    rst = 1'b0;
    exp_req_cyc = cyc + 1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    lat      = 1;
    p_ready  = 100;
    p_redir  = 0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'd0;
    bus.instr_ready_i = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'd0;
    reset_model();

    // First fetch at RESET_PC, field decode of a known word, then sequential run.
    do_reset();
    word_q.push_back(32'h4020_8033);
    for (int i = 0; i < 10 && !bus.instr_valid_o; i++) cycle();
    check_val("first_valid", {31'd0, bus.instr_valid_o}, 32'd1);
    check_val("first_pc",    bus.pc_o,                   32'h0000_0100);
    check_val("first_op",    {25'd0, bus.op_code_o},     32'h33);
    check_val("first_f3",    {29'd0, bus.funct3_o},      32'h0);
    check_val("first_f7h",   {31'd0, bus.fnc7_h20_o},    32'h1);
    run(12);

    // Slow memory with heavy backpressure and a forced long stall.
    lat = 4;
    p_ready = 30;
    run(60);
    p_ready = 0;
    run(12);
    p_ready = 100;
    run(10);

    // Explicit redirects: 0x200 -> 0x080 -> 0x200 -> fall-through 0x204.
    lat = 1;
    force_q.push_back({1'b1, 32'h0000_0200});
    force_q.push_back({1'b1, 32'h0000_0080});
    force_q.push_back({1'b1, 32'h0000_0200});
    force_q.push_back({1'b0, 32'h0000_0002});
    run(16);

    // Random aligned redirects with random latency and readiness.
    p_redir = 40;
    for (int k = 0; k < 6; k++) begin
      lat     = $urandom_range(1, 5);
      p_ready = $urandom_range(30, 100);
      run(25);
    end

    // PC wrap from 0xFFFF_FFFC to 0 is a normal fetch.
    p_redir = 0;
    p_ready = 100;
    lat     = 1;
    for (int i = 0; i < 10 && force_q.size() == 0; i++) begin
      if (bus.instr_valid_o) force_q.push_back({1'b1, 32'hFFFF_FFFC});
      else cycle();
    end
    run(12);

    // Misaligned redirect: sticky error, no requests, cleared only by reset.
    force_q.push_back({1'b1, 32'h0000_0102});
    for (int i = 0; i < 20 && !err_exp; i++) cycle();
    run(22);
    check_val("err_sticky", {31'd0, bus.fetch_err_o}, 32'd1);
    do_reset();
    run(10);

    // Reset while waiting on a slow response.
    lat = 4;
    for (int i = 0; i < 20 && !(mem_due > cyc); i++) cycle();
    cycle();
    do_reset();
    lat = 2;
    run(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the decode `controller`. Holds the program counter, fetches one 32-bit instruction per transaction over a request/response instruction-memory port, and presents the instruction plus its decoded `op_code`/`funct3`/`funct7[5]` fields to the controller. It consumes the resolved jump/branch redirect produced downstream to select the next PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `imem_req_o`  out  1  fetch request; high for exactly one cycle per transaction.
- `imem_addr_o`  out  32  fetch address; equals `pc_o`.
- `imem_rvalid_i`  in  1  response valid; earliest one cycle after the request.
- `imem_rdata_i`  in  32  response instruction word.
- `instr_valid_o`  out  1  `instr_o`/`pc_o` hold a fetched instruction.
- `instr_ready_i`  in  1  downstream accepts/retires the instruction this cycle.
- `instr_o`  out  32  fetched instruction.
- `pc_o`  out  32  PC of `instr_o`.
- `op_code_o`  out  7  `instr_o[6:0]`.
- `funct3_o`  out  3  `instr_o[14:12]`.
- `fnc7_h20_o`  out  1  `instr_o[30]`.
- `redirect_i`  in  1  taken jal/jalr/branch for the current instruction.
- `redirect_pc_i`  in  32  target PC when `redirect_i`=1.
- `fetch_err_o`  out  1  sticky misaligned-target error.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, ERR.
- IDLE: entered on reset; unconditionally -> REQ next cycle.
- REQ: `imem_req_o`=1, `imem_addr_o`=PC; -> WAIT.
- WAIT: `imem_req_o`=0; on `imem_rvalid_i`=1, register `imem_rdata_i` into `instr_o` and -> HOLD; otherwise stay (no timeout).
- HOLD: `instr_valid_o`=1; `instr_o` and `pc_o` are stable. On `instr_ready_i`=1: next PC = `redirect_i` ? `redirect_pc_i` : PC+4, then -> REQ. If next PC[1:0] != 2'b00, go to ERR instead and load no new PC.
- ERR: `fetch_err_o`=1, `instr_valid_o`=0, no requests; remains until `rst_i`.
- `redirect_i`/`redirect_pc_i` are sampled only in HOLD with `instr_ready_i`=1; ignored otherwise.
- `imem_rvalid_i` outside WAIT is ignored, as is `imem_rdata_i` when `imem_rvalid_i`=0.
- PC+4 is computed modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000. This is not an error.
- `op_code_o`, `funct3_o`, and `fnc7_h20_o` are combinational slices of registered `instr_o`.

## Timing
- Reset values: state IDLE, `pc_o`=`RESET_PC`, `instr_o`=32'h0000_0013 (NOP), `instr_valid_o`=0, `imem_req_o`=0, `imem_addr_o`=`RESET_PC`, `fetch_err_o`=0. Field outputs follow `instr_o`: `op_code_o`=7'h13, `funct3_o`=0, `fnc7_h20_o`=0.
- First request: the cycle after `rst_i` falls, the FSM is in IDLE; `imem_req_o`=1 in the following cycle.
- With a 1-cycle memory:
  - Request in cycle c, `rvalid` in c+1, `instr_valid_o`=1 in c+2.
  - If accepted in c+2, the next request issues in c+3. Peak throughput is one instruction per 3 cycles.
- Backpressure: `instr_valid_o` stays high and all outputs stay frozen for as long as `instr_ready_i`=0.
- Reset mid-transaction (REQ/WAIT/HOLD) abandons it within one cycle. The memory is reset by the same `rst_i`, so no stale response follows.
- `rst_i` has priority over every other input in every state, including ERR.

## Test plan
- Reset with `RESET_PC`=0x100, memory latency 1, `instr_ready_i`=1 -> first `imem_req_o` with addr 0x100 two cycles after reset release. `instr_valid_o` in cycle req+2; `op_code_o`/`funct3_o`/`fnc7_h20_o` match the returned word (e.g. 0x40208033 -> 7'h33, 3'h0, 1).
- Sequential fetch of 4 instructions -> addresses 0x100, 0x104, 0x108, 0x10C, with requests exactly 3 cycles apart.
- Hold `instr_ready_i`=0 for 5 cycles, memory latency 4 -> `instr_o`/`pc_o` stable and no new `imem_req_o`; `rvalid` pulse outside WAIT ignored.
- In HOLD at PC 0x200, accept with `redirect_i`=1, `redirect_pc_i`=0x080 -> next request addr 0x080. With `redirect_i`=0 -> 0x204.
- Accept with `redirect_pc_i`=0x102 -> ERR, `fetch_err_o`=1, no further requests for 20 cycles; `rst_i` clears it and restarts at `RESET_PC`.
- PC 0xFFFF_FFFC accepted without redirect -> next addr 0x0000_0000, `fetch_err_o`=0. Separately, assert `rst_i` in WAIT -> all outputs return to reset values next cycle.
